// File: rtl/lc3_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : lc3_reg_file
// Brief    : LC-3 eight-entry general-purpose register file with NZP condition
//            codes and a per-register busy scoreboard for hazard detection.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Register storage element: WIDTH-bit register with load enable.
// ----------------------------------------------------------------------------
module lc3_reg16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// ----------------------------------------------------------------------------
// Register file top level.
// ----------------------------------------------------------------------------
module lc3_reg_file #(
    parameter int WIDTH  = 16,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [2:0]       sr1_addr,
    output logic [WIDTH-1:0] sr1_data,
    input  logic [2:0]       sr2_addr,
    output logic [WIDTH-1:0] sr2_data,
    input  logic             set_cc,
    input  logic [WIDTH-1:0] cc_src,
    output logic [2:0]       nzp,
    input  logic             issue_en,
    input  logic [2:0]       issue_addr,
    output logic [7:0]       busy
);

    localparam int          c_NUM_REGS  = 8;
    localparam logic [2:0]  c_NZP_RESET = 3'b010;

    logic [WIDTH-1:0] w_regs [0:c_NUM_REGS-1];
    logic [7:0]       w_wr_sel;
    logic [7:0]       w_issue_sel;
    logic [7:0]       r_busy;
    logic [2:0]       r_nzp;

    logic [WIDTH-1:0] w_sr1_stored;
    logic [WIDTH-1:0] w_sr2_stored;
    logic             w_sr1_fwd;
    logic             w_sr2_fwd;

    logic             w_cc_neg;
    logic             w_cc_zero;
    logic             w_cc_pos;

    // ------------------------------------------------------------------
    // Register array and per-register scoreboard bit
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < c_NUM_REGS; i++) begin : g_regs
            assign w_wr_sel[i]    = wr_en    && (wr_addr    == 3'(i));
            assign w_issue_sel[i] = issue_en && (issue_addr == 3'(i));

            lc3_reg16 #(
                .WIDTH (WIDTH)
            ) u_reg (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (w_wr_sel[i]),
                .d     (wr_data),
                .q     (w_regs[i])
            );

            // A new issue outranks a retiring write: the new writer is still pending.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_busy[i] <= 1'b0;
                end else if (w_issue_sel[i]) begin
                    r_busy[i] <= 1'b1;
                end else if (w_wr_sel[i]) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read ports with optional same-cycle write forwarding
    // ------------------------------------------------------------------
    assign w_sr1_stored = w_regs[sr1_addr];
    assign w_sr2_stored = w_regs[sr2_addr];

    generate
        if (BYPASS != 0) begin : g_bypass
            assign w_sr1_fwd = wr_en && (wr_addr == sr1_addr);
            assign w_sr2_fwd = wr_en && (wr_addr == sr2_addr);
        end else begin : g_no_bypass
            assign w_sr1_fwd = 1'b0;
            assign w_sr2_fwd = 1'b0;
        end
    endgenerate

    assign sr1_data = w_sr1_fwd ? wr_data : w_sr1_stored;
    assign sr2_data = w_sr2_fwd ? wr_data : w_sr2_stored;

    // ------------------------------------------------------------------
    // Condition codes: exactly one of N/Z/P is ever set
    // ------------------------------------------------------------------
    assign w_cc_neg  = cc_src[WIDTH-1];
    assign w_cc_zero = (cc_src == '0);
    assign w_cc_pos  = !w_cc_neg && !w_cc_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nzp <= c_NZP_RESET;
        end else if (set_cc) begin
            r_nzp <= {w_cc_neg, w_cc_zero, w_cc_pos};
        end
    end

    assign nzp  = r_nzp;
    assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_lc3_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_reg_file
// Brief    : Directed self-checking bench; drives a BYPASS=1 and a BYPASS=0
//            instance from the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_lc3_reg_file;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [2:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [2:0]       sr1_addr;
    logic [2:0]       sr2_addr;
    logic             set_cc;
    logic [WIDTH-1:0] cc_src;
    logic             issue_en;
    logic [2:0]       issue_addr;

    logic [WIDTH-1:0] b_sr1, b_sr2, n_sr1, n_sr2;
    logic [2:0]       b_nzp, n_nzp;
    logic [7:0]       b_busy, n_busy;

    int n_checks;
    int n_fail;

    lc3_reg_file #(.WIDTH(WIDTH), .BYPASS(1)) dut_byp (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .sr1_addr   (sr1_addr),
        .sr1_data   (b_sr1),
        .sr2_addr   (sr2_addr),
        .sr2_data   (b_sr2),
        .set_cc     (set_cc),
        .cc_src     (cc_src),
        .nzp        (b_nzp),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .busy       (b_busy)
    );

    lc3_reg_file #(.WIDTH(WIDTH), .BYPASS(0)) dut_nob (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .sr1_addr   (sr1_addr),
        .sr1_data   (n_sr1),
        .sr2_addr   (sr2_addr),
        .sr2_data   (n_sr2),
        .set_cc     (set_cc),
        .cc_src     (cc_src),
        .nzp        (n_nzp),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .busy       (n_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        wr_en    = 1'b0;
        issue_en = 1'b0;
        set_cc   = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            sr1_addr = 3'(i);
            sr2_addr = 3'(7 - i);
            #1;
            n_checks++;
            if (b_sr1 !== 16'h0000 || b_sr2 !== 16'h0000 || n_sr1 !== 16'h0000 || n_sr2 !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_read R%0d: got byp %h/%h nob %h/%h, want 0000", i, b_sr1, b_sr2, n_sr1, n_sr2);
            end
        end
        n_checks++;
        if (b_nzp !== 3'b010 || n_nzp !== 3'b010 || b_busy !== 8'h00 || n_busy !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: nzp %b/%b busy %h/%h, want 010 / 00", b_nzp, n_nzp, b_busy, n_busy);
        end
        @(negedge clk) rst_n = 1'b1;

        // Load some state, then assert reset between edges.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hAAAA;
        issue_en = 1'b1; issue_addr = 3'd1;
        set_cc = 1'b1; cc_src = 16'h0001;
        @(posedge clk); #1;
        idle_inputs();
        sr1_addr = 3'd0;
        #1;
        n_checks++;
        if (n_sr1 !== 16'hAAAA || n_busy !== 8'h02 || n_nzp !== 3'b001) begin
            n_fail++;
            $display("FAIL pre_async_state: got R0 %h busy %h nzp %b, want AAAA 02 001", n_sr1, n_busy, n_nzp);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (b_sr1 !== 16'h0000 || n_sr1 !== 16'h0000 || b_busy !== 8'h00 || n_busy !== 8'h00
            || b_nzp !== 3'b010 || n_nzp !== 3'b010) begin
            n_fail++;
            $display("FAIL async_reset: got R0 %h/%h busy %h/%h nzp %b/%b, want 0000 00 010",
                     b_sr1, n_sr1, b_busy, n_busy, b_nzp, n_nzp);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_write();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 16'h1110 + 16'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        sr1_addr = 3'd3; sr2_addr = 3'd6;
        #1;
        n_checks++;
        if (b_sr1 !== 16'h1113 || b_sr2 !== 16'h1116 || n_sr1 !== 16'h1113 || n_sr2 !== 16'h1116) begin
            n_fail++;
            $display("FAIL write_read: got byp %h/%h nob %h/%h, want 1113/1116", b_sr1, b_sr2, n_sr1, n_sr2);
        end
        wr_data = 16'hFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            sr1_addr = 3'(i);
            sr2_addr = 3'(i);
            #1;
            n_checks++;
            if (b_sr1 !== 16'h1110 + 16'(i) || n_sr2 !== 16'h1110 + 16'(i)) begin
                n_fail++;
                $display("FAIL hold_R%0d: got %h/%h, want %h", i, b_sr1, n_sr2, 16'h1110 + 16'(i));
            end
        end
        n_checks++;
        if (b_busy !== 8'h00) begin
            n_fail++;
            $display("FAIL write_nonbusy: busy got %h, want 00", b_busy);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF;
        sr1_addr = 3'd5; sr2_addr = 3'd5;
        #1;
        n_checks++;
        if (b_sr1 !== 16'hBEEF || b_sr2 !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL bypass_fwd: got %h/%h, want BEEF", b_sr1, b_sr2);
        end
        n_checks++;
        if (n_sr1 !== 16'h1115 || n_sr2 !== 16'h1115) begin
            n_fail++;
            $display("FAIL nobypass_old: got %h/%h, want 1115", n_sr1, n_sr2);
        end
        sr2_addr = 3'd4;
        #1;
        n_checks++;
        if (b_sr2 !== 16'h1114) begin
            n_fail++;
            $display("FAIL bypass_other_port: got %h, want 1114", b_sr2);
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
        #1;
        n_checks++;
        if (b_sr1 !== 16'hBEEF || n_sr1 !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL post_edge_R5: got %h/%h, want BEEF", b_sr1, n_sr1);
        end
    endtask

    task automatic test_cc();
        logic [WIDTH-1:0] srcs [4];
        logic             sets [4];
        logic [2:0]       exps [4];
        srcs = '{16'h8000, 16'h0000, 16'h7FFF, 16'h8000};
        sets = '{1'b1, 1'b1, 1'b1, 1'b0};
        exps = '{3'b100, 3'b010, 3'b001, 3'b001};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_cc = sets[i]; cc_src = srcs[i];
            @(posedge clk); #1;
            n_checks++;
            if (b_nzp !== exps[i] || n_nzp !== exps[i]) begin
                n_fail++;
                $display("FAIL cc_%0d src %h set %b: got %b/%b, want %b",
                         i, srcs[i], sets[i], b_nzp, n_nzp, exps[i]);
            end
        end
        set_cc = 1'b0;
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        issue_en = 1'b1; issue_addr = 3'd2;
        @(posedge clk); #1;
        n_checks++;
        if (b_busy !== 8'h04 || n_busy !== 8'h04) begin
            n_fail++;
            $display("FAIL sb_issue_R2: got %h/%h, want 04", b_busy, n_busy);
        end
        @(negedge clk);
        issue_en = 1'b0; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h2222;
        @(posedge clk); #1;
        n_checks++;
        if (b_busy !== 8'h00) begin
            n_fail++;
            $display("FAIL sb_retire_R2: got %h, want 00", b_busy);
        end
        @(negedge clk);
        issue_en = 1'b1; issue_addr = 3'd4; wr_en = 1'b1; wr_addr = 3'd2;
        @(posedge clk); #1;
        n_checks++;
        if (b_busy !== 8'h10) begin
            n_fail++;
            $display("FAIL sb_issue4_write2: got %h, want 10", b_busy);
        end
        @(negedge clk);
        issue_en = 1'b1; issue_addr = 3'd4; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4444;
        @(posedge clk); #1;
        n_checks++;
        if (b_busy !== 8'h10 || n_busy !== 8'h10) begin
            n_fail++;
            $display("FAIL sb_set_priority: got %h/%h, want 10", b_busy, n_busy);
        end
        idle_inputs();
        sr1_addr = 3'd4;
        #1;
        n_checks++;
        if (b_sr1 !== 16'h4444) begin
            n_fail++;
            $display("FAIL sb_write_R4_data: got %h, want 4444", b_sr1);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h1234;
        set_cc = 1'b1; cc_src = 16'h8000;
        issue_en = 1'b1; issue_addr = 3'd7;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk); #1;
        sr1_addr = 3'd1; sr2_addr = 3'd4;
        #1;
        n_checks++;
        if (b_sr1 !== 16'h0000 || n_sr1 !== 16'h0000 || b_sr2 !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset_regs: got R1 %h/%h R4 %h, want 0000", b_sr1, n_sr1, b_sr2);
        end
        n_checks++;
        if (b_nzp !== 3'b010 || n_nzp !== 3'b010 || b_busy !== 8'h00 || n_busy !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset_state: nzp %b/%b busy %h/%h, want 010 / 00", b_nzp, n_nzp, b_busy, n_busy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        wr_addr  = '0; wr_data = '0;
        sr1_addr = '0; sr2_addr = '0;
        cc_src   = '0; issue_addr = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        test_reset();
        test_write();
        test_bypass();
        test_cc();
        test_scoreboard();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
